// File: rtl/asu_ddr5_pkg.sv
// Shared types and burst constants for the DDR5 DFI write path.
package asu_ddr5_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WAIT,
    DATA,
    GAP
  } wr_seq_state_e;

  localparam int BL8_CYCLES  = 2;
  localparam int BL16_CYCLES = 4;

endpackage

// File: rtl/asu_dfi_wdata_fifo.sv
// Write-data FIFO with occupancy count; the read port is combinational from the head entry.
// Pushes are refused while full (even with a simultaneous pop); pops on empty are ignored.
module asu_dfi_wdata_fifo #(
  parameter int pDEPTH = 8,
  parameter int pWIDTH = 18
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [pWIDTH-1:0]        push_data_i,
  input  logic                     pop_i,
  output logic [pWIDTH-1:0]        pop_data_o,
  output logic                     full_o,
  output logic [$clog2(pDEPTH):0]  count_o
);

  localparam int AW = $clog2(pDEPTH);
  localparam int CW = AW + 1;

  logic [pWIDTH-1:0] mem [pDEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  assign full_o     = (count == CW'(pDEPTH));
  assign do_push    = push_i & ~full_o;
  assign do_pop     = pop_i & (count != '0);
  assign pop_data_o = mem[rd_ptr];
  assign count_o    = count;

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/asu_dfi_wr_sequencer.sv
// Turns write/MRW requests plus queued write data into registered DFI p0/p1 signals.
// Command appears one cycle after accept, data pWR_LAT cycles later; requests wait until enough data is queued.
module asu_dfi_wr_sequencer
  import asu_ddr5_pkg::*;
#(
  parameter int pDRAM_SIZE  = 4,
  parameter int pNUM_RANK   = 1,
  parameter int pWR_LAT     = 3,
  parameter int pGAP        = 2,
  parameter int pFIFO_DEPTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_mrw_i,
  input  logic                    req_bl8_i,
  input  logic [pNUM_RANK-1:0]    req_rank_i,
  input  logic [13:0]             req_ca0_i,
  input  logic [13:0]             req_ca1_i,
  input  logic                    wd_valid_i,
  output logic                    wd_ready_o,
  input  logic [4*pDRAM_SIZE-1:0] wd_data_i,
  input  logic [pDRAM_SIZE/2-1:0] wd_mask_i,
  input  logic [pNUM_RANK-1:0]    dram_reset_n_i,
  output logic [pNUM_RANK-1:0]    dfi_cs_n_p0_o,
  output logic [pNUM_RANK-1:0]    dfi_cs_n_p1_o,
  output logic [13:0]             dfi_address_p0_o,
  output logic [13:0]             dfi_address_p1_o,
  output logic [pNUM_RANK-1:0]    dfi_reset_n_p0_o,
  output logic [pNUM_RANK-1:0]    dfi_reset_n_p1_o,
  output logic                    dfi_wrdata_en_p0_o,
  output logic                    dfi_wrdata_en_p1_o,
  output logic [2*pDRAM_SIZE-1:0] dfi_wrdata_p0_o,
  output logic [2*pDRAM_SIZE-1:0] dfi_wrdata_p1_o,
  output logic [pDRAM_SIZE/4-1:0] dfi_wrdata_mask_p0_o,
  output logic [pDRAM_SIZE/4-1:0] dfi_wrdata_mask_p1_o
);

  localparam int DW = 2 * pDRAM_SIZE;
  localparam int MW = pDRAM_SIZE / 4;
  localparam int FW = 2 * DW + 2 * MW;
  localparam int CW = $clog2(pFIFO_DEPTH) + 1;
  localparam logic [3:0] WAIT_LOAD = 4'(pWR_LAT > 1 ? pWR_LAT - 2 : 0);
  localparam logic [3:0] GAP_LOAD  = 4'(pGAP > 0 ? pGAP - 1 : 0);

  wr_seq_state_e state, state_n;
  logic [3:0]    cnt, cnt_n;
  logic          run_q;
  logic          mrw_q;
  logic          bl8_q;
  logic [pNUM_RANK-1:0] rank_q;
  logic [13:0]   ca0_q;
  logic [13:0]   ca1_q;

  logic [CW-1:0] fifo_count;
  logic [CW-1:0] need_cnt;
  logic [FW-1:0] fifo_rd;
  logic          fifo_full;
  logic          fifo_pop;
  logic          accept;
  logic [3:0]    beat_last;
  logic [DW-1:0] rd_data_p0, rd_data_p1;
  logic [MW-1:0] rd_mask_p0, rd_mask_p1;

  asu_dfi_wdata_fifo #(
    .pDEPTH (pFIFO_DEPTH),
    .pWIDTH (FW)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (wd_valid_i),
    .push_data_i ({wd_mask_i, wd_data_i}),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_rd),
    .full_o      (fifo_full),
    .count_o     (fifo_count)
  );

  assign wd_ready_o = ~fifo_full;
  assign {rd_mask_p1, rd_mask_p0, rd_data_p1, rd_data_p0} = fifo_rd;

  // run_q keeps req_ready low through reset and the first cycle after release.
  assign need_cnt    = req_bl8_i ? CW'(BL8_CYCLES) : CW'(BL16_CYCLES);
  assign req_ready_o = run_q & (state == IDLE) & (req_mrw_i | (fifo_count >= need_cnt));
  assign accept      = req_valid_i & req_ready_o;
  assign beat_last   = bl8_q ? 4'(BL8_CYCLES - 1) : 4'(BL16_CYCLES - 1);
  assign fifo_pop    = (state == DATA);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      run_q  <= 1'b0;
      mrw_q  <= 1'b0;
      bl8_q  <= 1'b0;
      rank_q <= '0;
      ca0_q  <= '0;
      ca1_q  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      run_q <= 1'b1;
      if (accept) begin
        mrw_q  <= req_mrw_i;
        bl8_q  <= req_bl8_i;
        rank_q <= req_rank_i;
        ca0_q  <= req_ca0_i;
        ca1_q  <= req_ca1_i;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (accept) state_n = CMD;
      end
      CMD: begin
        if (mrw_q) begin
          if (pGAP > 0) begin
            state_n = GAP;
            cnt_n   = GAP_LOAD;
          end else begin
            state_n = IDLE;
          end
        end else if (pWR_LAT > 1) begin
          state_n = WAIT;
          cnt_n   = WAIT_LOAD;
        end else begin
          state_n = DATA;
          cnt_n   = beat_last;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_n = DATA;
          cnt_n   = beat_last;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      DATA: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (pGAP > 0) begin
          state_n = GAP;
          cnt_n   = GAP_LOAD;
        end else begin
          state_n = IDLE;
        end
      end
      GAP: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n = cnt - 1'b1;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Write data/mask only load during DATA so the bus holds its last beat afterwards.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      dfi_cs_n_p0_o        <= '1;
      dfi_cs_n_p1_o        <= '1;
      dfi_address_p0_o     <= '0;
      dfi_address_p1_o     <= '0;
      dfi_reset_n_p0_o     <= '0;
      dfi_reset_n_p1_o     <= '0;
      dfi_wrdata_en_p0_o   <= 1'b0;
      dfi_wrdata_en_p1_o   <= 1'b0;
      dfi_wrdata_p0_o      <= '0;
      dfi_wrdata_p1_o      <= '0;
      dfi_wrdata_mask_p0_o <= '0;
      dfi_wrdata_mask_p1_o <= '0;
    end else begin
      dfi_reset_n_p0_o   <= dram_reset_n_i;
      dfi_reset_n_p1_o   <= dram_reset_n_i;
      dfi_cs_n_p0_o      <= (state == CMD) ? ~rank_q : '1;
      dfi_cs_n_p1_o      <= '1;
      dfi_address_p0_o   <= (state == CMD) ? ca0_q : '0;
      dfi_address_p1_o   <= (state == CMD) ? ca1_q : '0;
      dfi_wrdata_en_p0_o <= (state == DATA);
      dfi_wrdata_en_p1_o <= (state == DATA);
      if (state == DATA) begin
        dfi_wrdata_p0_o      <= rd_data_p0;
        dfi_wrdata_p1_o      <= rd_data_p1;
        dfi_wrdata_mask_p0_o <= rd_mask_p0;
        dfi_wrdata_mask_p1_o <= rd_mask_p1;
      end
    end
  end

endmodule

// File: tb/tb_asu_dfi_wr_sequencer.sv
// Scoreboard bench: the driver queues expected commands/beats with their cycle stamps, a negedge monitor checks them.
module tb_asu_dfi_wr_sequencer;

  localparam int WL = 3;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_mrw_i, req_bl8_i;
  logic [0:0]  req_rank_i;
  logic [13:0] req_ca0_i, req_ca1_i;
  logic        wd_valid_i, wd_ready_o;
  logic [15:0] wd_data_i;
  logic [1:0]  wd_mask_i;
  logic [0:0]  dram_reset_n_i;
  logic [0:0]  dfi_cs_n_p0_o, dfi_cs_n_p1_o, dfi_reset_n_p0_o, dfi_reset_n_p1_o;
  logic [13:0] dfi_address_p0_o, dfi_address_p1_o;
  logic        dfi_wrdata_en_p0_o, dfi_wrdata_en_p1_o;
  logic [7:0]  dfi_wrdata_p0_o, dfi_wrdata_p1_o;
  logic [0:0]  dfi_wrdata_mask_p0_o, dfi_wrdata_mask_p1_o;

  asu_dfi_wr_sequencer #(
    .pDRAM_SIZE(4), .pNUM_RANK(1), .pWR_LAT(WL), .pGAP(2), .pFIFO_DEPTH(8)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_mrw_i(req_mrw_i),
    .req_bl8_i(req_bl8_i), .req_rank_i(req_rank_i), .req_ca0_i(req_ca0_i), .req_ca1_i(req_ca1_i),
    .wd_valid_i(wd_valid_i), .wd_ready_o(wd_ready_o), .wd_data_i(wd_data_i), .wd_mask_i(wd_mask_i),
    .dram_reset_n_i(dram_reset_n_i),
    .dfi_cs_n_p0_o(dfi_cs_n_p0_o), .dfi_cs_n_p1_o(dfi_cs_n_p1_o),
    .dfi_address_p0_o(dfi_address_p0_o), .dfi_address_p1_o(dfi_address_p1_o),
    .dfi_reset_n_p0_o(dfi_reset_n_p0_o), .dfi_reset_n_p1_o(dfi_reset_n_p1_o),
    .dfi_wrdata_en_p0_o(dfi_wrdata_en_p0_o), .dfi_wrdata_en_p1_o(dfi_wrdata_en_p1_o),
    .dfi_wrdata_p0_o(dfi_wrdata_p0_o), .dfi_wrdata_p1_o(dfi_wrdata_p1_o),
    .dfi_wrdata_mask_p0_o(dfi_wrdata_mask_p0_o), .dfi_wrdata_mask_p1_o(dfi_wrdata_mask_p1_o)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [13:0] a0; logic [13:0] a1; } cmd_t;
  typedef struct { int cyc; logic [7:0] d0; logic [7:0] d1; logic m0; logic m1; } beat_t;

  cmd_t        cmd_q[$];
  beat_t       beat_q[$];
  logic [17:0] model_q[$];
  cmd_t        mc;
  beat_t       mb;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: any asserted chip select or write enable must match the head of its queue.
  always @(negedge clk) begin
    if (rst_i) begin
      if (dfi_cs_n_p0_o !== 1'b1) begin
        if (cmd_q.size() == 0) chk("cmd_unexpected", 32'(dfi_address_p0_o), 32'hFFFF_FFFF);
        else begin
          mc = cmd_q.pop_front();
          chk("cmd_cycle", cyc, mc.cyc);
          chk("cmd_addr_p0", 32'(dfi_address_p0_o), 32'(mc.a0));
          chk("cmd_addr_p1", 32'(dfi_address_p1_o), 32'(mc.a1));
          chk("cmd_cs_n_p1", 32'(dfi_cs_n_p1_o), 32'd1);
        end
      end
      if (dfi_wrdata_en_p0_o || dfi_wrdata_en_p1_o) begin
        if (beat_q.size() == 0) chk("beat_unexpected", 32'(dfi_wrdata_p0_o), 32'hFFFF_FFFF);
        else begin
          mb = beat_q.pop_front();
          chk("beat_cycle", cyc, mb.cyc);
          chk("beat_en_pair", {30'd0, dfi_wrdata_en_p0_o, dfi_wrdata_en_p1_o}, 32'd3);
          chk("beat_data_p0", 32'(dfi_wrdata_p0_o), 32'(mb.d0));
          chk("beat_data_p1", 32'(dfi_wrdata_p1_o), 32'(mb.d1));
          chk("beat_mask", {30'd0, dfi_wrdata_mask_p1_o, dfi_wrdata_mask_p0_o}, {30'd0, mb.m1, mb.m0});
        end
      end
    end
  end

  task automatic push(input logic [15:0] d, input logic [1:0] m);
    wd_valid_i = 1'b1;
    wd_data_i  = d;
    wd_mask_i  = m;
    if (wd_ready_o) model_q.push_back({m, d});
    @(posedge clk); #1;
    wd_valid_i = 1'b0;
  endtask

  task automatic send_req(input logic mrw, input logic bl8, input logic [13:0] ca0,
                          input logic [13:0] ca1, output int t);
    logic [17:0] e;
    bit ok;
    int n;
    req_mrw_i = mrw; req_bl8_i = bl8; req_ca0_i = ca0; req_ca1_i = ca1;
    req_rank_i = 1'b1; req_valid_i = 1'b1;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (req_ready_o) begin ok = 1; break; end
    end
    if (!ok) begin
      chk("req_accept_timeout", 32'd0, 32'd1);
      req_valid_i = 1'b0;
      t = -100;
      return;
    end
    t = cyc + 1;
    cmd_q.push_back('{cyc: t + 1, a0: ca0, a1: ca1});
    if (!mrw) begin
      n = bl8 ? 2 : 4;
      for (int i = 0; i < n; i++) begin
        e = model_q.pop_front();
        beat_q.push_back('{cyc: t + 1 + WL + i, d0: e[7:0], d1: e[15:8], m0: e[16], m1: e[17]});
      end
    end
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (cmd_q.size() != 0 || beat_q.size() != 0); i++) begin
      @(posedge clk); #1;
    end
    chk("drain_pending", cmd_q.size() + beat_q.size(), 0);
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset();
    chk("rst_cs_n_p0", 32'(dfi_cs_n_p0_o), 1);
    chk("rst_cs_n_p1", 32'(dfi_cs_n_p1_o), 1);
    chk("rst_addr_p0", 32'(dfi_address_p0_o), 0);
    chk("rst_addr_p1", 32'(dfi_address_p1_o), 0);
    chk("rst_reset_n", {dfi_reset_n_p1_o, dfi_reset_n_p0_o}, 0);
    chk("rst_wrdata_en", {dfi_wrdata_en_p1_o, dfi_wrdata_en_p0_o}, 0);
    chk("rst_wrdata", {dfi_wrdata_p1_o, dfi_wrdata_p0_o}, 0);
    chk("rst_mask", {dfi_wrdata_mask_p1_o, dfi_wrdata_mask_p0_o}, 0);
    chk("rst_req_ready", 32'(req_ready_o), 0);
    chk("rst_wd_ready", 32'(wd_ready_o), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_i = 1'b0; req_valid_i = 1'b0; req_mrw_i = 1'b1; req_bl8_i = 1'b0;
    req_rank_i = 1'b1; req_ca0_i = '0; req_ca1_i = '0;
    wd_valid_i = 1'b0; wd_data_i = '0; wd_mask_i = '0; dram_reset_n_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    @(negedge clk); rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_n_follow", {dfi_reset_n_p1_o, dfi_reset_n_p0_o}, 2'b11);
    req_mrw_i = 1'b0;

    // BL16 with back-pressure until the fourth entry lands
    push(16'hB1A1, 2'b01);
    push(16'hB2A2, 2'b10);
    push(16'hB3A3, 2'b00);
    req_bl8_i = 1'b0; req_valid_i = 1'b1; #1;
    chk("bp_ready_3_entries", 32'(req_ready_o), 0);
    push(16'hB4A4, 2'b11);
    chk("bp_ready_4_entries", 32'(req_ready_o), 1);
    send_req(1'b0, 1'b0, 14'h280D, 14'h340D, t);
    drain();

    // BL8: two cycles only, bus holds the final beat afterwards
    push(16'hCCAA, 2'b01);
    push(16'hEE55, 2'b10);
    send_req(1'b0, 1'b1, 14'h0123, 14'h0456, t);
    drain();
    chk("hold_wrdata_p0", 32'(dfi_wrdata_p0_o), 32'h55);
    chk("hold_wrdata_p1", 32'(dfi_wrdata_p1_o), 32'hEE);
    chk("hold_en_low", {dfi_wrdata_en_p1_o, dfi_wrdata_en_p0_o}, 0);

    // MRW with empty FIFO: command only, ready returns after the gap
    send_req(1'b1, 1'b0, 14'h0A0B, 14'h0C0D, t);
    wait_until(t + 2);
    chk("mrw_ready_in_gap", 32'(req_ready_o), 0);
    chk("mrw_no_wrdata_en", 32'(dfi_wrdata_en_p0_o), 0);
    wait_until(t + 3);
    chk("mrw_ready_back", 32'(req_ready_o), 1);
    req_mrw_i = 1'b0;
    drain();

    // FIFO full: the ninth push is dropped, the eight queued entries feed two BL16 bursts
    for (int i = 0; i < 8; i++) push({8'(8'h90 + i), 8'(8'h10 + i)}, 2'(i));
    chk("full_wd_ready", 32'(wd_ready_o), 0);
    push(16'hDEAD, 2'b11);
    chk("full_model_count", model_q.size(), 8);
    send_req(1'b0, 1'b0, 14'h1111, 14'h2222, t);
    send_req(1'b0, 1'b0, 14'h3333, 14'h0444, t);
    drain();
    req_bl8_i = 1'b1; req_mrw_i = 1'b0; #1;
    chk("full_then_empty_ready", 32'(req_ready_o), 0);

    // Reset mid-BL16 burst
    push(16'h7161, 2'b00);
    push(16'h7262, 2'b01);
    push(16'h7363, 2'b10);
    push(16'h7464, 2'b11);
    send_req(1'b0, 1'b0, 14'h0555, 14'h0666, t);
    wait_until(t + 5);
    rst_i = 1'b0;
    beat_q.delete(); cmd_q.delete(); model_q.delete();
    req_mrw_i = 1'b1;
    @(posedge clk); #1;
    check_reset();
    @(negedge clk); rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    req_mrw_i = 1'b0; req_bl8_i = 1'b1; #1;
    chk("post_rst_fifo_empty", 32'(req_ready_o), 0);
    chk("post_rst_wd_ready", 32'(wd_ready_o), 1);
    chk("post_rst_en_low", {dfi_wrdata_en_p1_o, dfi_wrdata_en_p0_o}, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("end_cmd_q_empty", cmd_q.size(), 0);
    chk("end_beat_q_empty", beat_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
